// File: rtl/mouse_pkg.sv
// mouse_pkg: shared types and constants for the PS/2 mouse packet sequencer.
//   - mouse_state_e : sequencer FSM states
//   - PS/2 command/response byte values
//   - bit positions inside the packet status byte
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_SEND,
    ST_WAIT_ACK,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_FAIL
  } mouse_state_e;

  localparam logic [7:0] CMD_EN_REPORT = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_ID        = 8'h00;

  localparam int STS_SYNC = 3;
  localparam int STS_XS   = 4;
  localparam int STS_YS   = 5;
  localparam int STS_XO   = 6;
  localparam int STS_YO   = 7;

endpackage

// File: rtl/mouse_timeout_cnt.sv
// mouse_timeout_cnt: saturating up-counter with synchronous clear.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : clear to 0 (wins over i_en)
//   i_en           : count one per cycle, saturating at i_limit
//   i_limit        : expiry threshold (may change at run time)
//   o_expired      : count >= i_limit
module mouse_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_en && r_cnt < i_limit) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt >= i_limit);

endmodule

// File: rtl/mouse_packet_sequencer.sv
// mouse_packet_sequencer: brings up a PS/2 mouse (waits for self-test,
// sends Enable Data Reporting, checks the ACK) and then frames 3-byte
// stream packets, presenting each complete packet with a one-cycle tx.
//   qzt_clk, rst_n        : clock, async active-low reset
//   rx_data/valid/err     : byte stream from the PS/2 receiver
//   cmd_data/req, cmd_ack : command handshake to the PS/2 transmitter
//   status/deltaX/deltaY  : last complete packet, updated only with tx
//   tx                    : one-cycle strobe, packet outputs updated
//   stream_on             : ACK received, packet framing active
//   fail                  : command retries exhausted (terminal)
// Build option: define MOUSE_OVF_CLAMP_EN to zero a delta (and clear its
// sign bit) whenever the matching overflow bit is set.
module mouse_packet_sequencer
  import mouse_pkg::*;
#(
  parameter int INIT_WAIT_CYC = 25_000_000,
  parameter int ACK_WAIT_CYC  = 1_000_000,
  parameter int BYTE_GAP_CYC  = 100_000,
  parameter int MAX_RETRY     = 3
) (
  input  logic       qzt_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] cmd_data,
  output logic       cmd_req,
  input  logic       cmd_ack,
  output logic [7:0] status,
  output logic [7:0] deltaX,
  output logic [7:0] deltaY,
  output logic       tx,
  output logic       stream_on,
  output logic       fail
);

  localparam int MAX_A = (INIT_WAIT_CYC > ACK_WAIT_CYC) ? INIT_WAIT_CYC : ACK_WAIT_CYC;
  localparam int MAX_P = (MAX_A > BYTE_GAP_CYC) ? MAX_A : BYTE_GAP_CYC;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int RW    = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [CW-1:0] L_INIT = CW'(INIT_WAIT_CYC);
  localparam logic [CW-1:0] L_ACK  = CW'(ACK_WAIT_CYC);
  localparam logic [CW-1:0] L_GAP  = CW'(BYTE_GAP_CYC);

  mouse_state_e r_state;
  logic         r_got_aa;
  logic [RW-1:0] r_retry;
  logic         r_cmd_req, r_stream_on, r_fail, r_tx;
  logic [7:0]   r_sh_status, r_sh_x;
  logic [7:0]   r_status, r_dx, r_dy;

  logic          w_byte_ok;   // byte accepted: an error strobe drops it
  logic [CW-1:0] w_wait_limit;
  logic          w_wait_exp, w_gap_exp;
  logic [RW-1:0] w_retry_nxt;
  logic [7:0]    w_st_out, w_dx_out, w_dy_out;

  assign w_byte_ok    = rx_valid & ~rx_err;
  assign w_retry_nxt  = r_retry + 1'b1;
  assign w_wait_limit = (r_state == ST_INIT) ? L_INIT : L_ACK;

  // One counter serves both the self-test wait and the ACK wait; it is held
  // at zero throughout SEND so WAIT_ACK always starts a fresh window.
  mouse_timeout_cnt #(.W(CW)) u_wait_cnt (
    .i_clk     (qzt_clk),
    .i_rst_n   (rst_n),
    .i_clr     (r_state == ST_SEND),
    .i_en      ((r_state == ST_INIT) || (r_state == ST_WAIT_ACK)),
    .i_limit   (w_wait_limit),
    .o_expired (w_wait_exp)
  );

  mouse_timeout_cnt #(.W(CW)) u_gap_cnt (
    .i_clk     (qzt_clk),
    .i_rst_n   (rst_n),
    .i_clr     (rx_valid),
    .i_en      (1'b1),
    .i_limit   (L_GAP),
    .o_expired (w_gap_exp)
  );

  // Byte 2 goes straight from rx_data to the output register, so it needs
  // no shadow copy of its own.
  always_comb begin
    w_st_out = r_sh_status;
    w_dx_out = r_sh_x;
    w_dy_out = rx_data;
`ifdef MOUSE_OVF_CLAMP_EN
    if (r_sh_status[STS_XO]) begin
      w_dx_out         = 8'h00;
      w_st_out[STS_XS] = 1'b0;
    end
    if (r_sh_status[STS_YO]) begin
      w_dy_out         = 8'h00;
      w_st_out[STS_YS] = 1'b0;
    end
`endif
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_got_aa    <= 1'b0;
      r_retry     <= '0;
      r_cmd_req   <= 1'b0;
      r_stream_on <= 1'b0;
      r_fail      <= 1'b0;
      r_tx        <= 1'b0;
      r_sh_status <= 8'h00;
      r_sh_x      <= 8'h00;
      r_status    <= 8'h00;
      r_dx        <= 8'h00;
      r_dy        <= 8'h00;
    end else begin
      r_tx <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (w_wait_exp) begin
            r_got_aa <= 1'b0;
            r_state  <= ST_SEND;
          end else if (rx_err) begin
            r_got_aa <= 1'b0;
          end else if (rx_valid) begin
            if (r_got_aa && rx_data == RSP_ID) begin
              r_got_aa <= 1'b0;
              r_state  <= ST_SEND;
            end else begin
              r_got_aa <= (rx_data == RSP_BAT_OK);
            end
          end
        end
        ST_SEND: begin
          // Request goes up one cycle after entry; an ack is only honoured
          // once the request is actually visible to the transmitter.
          if (r_cmd_req && cmd_ack) begin
            r_cmd_req <= 1'b0;
            r_state   <= ST_WAIT_ACK;
          end else begin
            r_cmd_req <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (w_byte_ok && rx_data == RSP_ACK) begin
            r_stream_on <= 1'b1;
            r_state     <= ST_B0;
          end else if (rx_err || rx_valid || w_wait_exp) begin
            r_retry <= w_retry_nxt;
            if (w_retry_nxt < RW'(MAX_RETRY)) begin
              r_state <= ST_SEND;
            end else begin
              r_fail  <= 1'b1;
              r_state <= ST_FAIL;
            end
          end
        end
        ST_B0: begin
          // Only a byte with the sync bit can start a packet.
          if (w_byte_ok && rx_data[STS_SYNC]) begin
            r_sh_status <= rx_data;
            r_state     <= ST_B1;
          end
        end
        ST_B1: begin
          if (rx_err || w_gap_exp) begin
            r_state <= ST_B0;
          end else if (rx_valid) begin
            r_sh_x  <= rx_data;
            r_state <= ST_B2;
          end
        end
        ST_B2: begin
          if (rx_err || w_gap_exp) begin
            r_state <= ST_B0;
          end else if (rx_valid) begin
            r_status <= w_st_out;
            r_dx     <= w_dx_out;
            r_dy     <= w_dy_out;
            r_tx     <= 1'b1;
            r_state  <= ST_B0;
          end
        end
        ST_FAIL: r_fail <= 1'b1;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign cmd_data  = CMD_EN_REPORT;
  assign cmd_req   = r_cmd_req;
  assign status    = r_status;
  assign deltaX    = r_dx;
  assign deltaY    = r_dy;
  assign tx        = r_tx;
  assign stream_on = r_stream_on;
  assign fail      = r_fail;

endmodule

// File: tb/tb_mouse_packet_sequencer.sv
// Directed bench for mouse_packet_sequencer with shortened timeouts.
module tb_mouse_packet_sequencer;

  localparam int INIT_W = 200;
  localparam int ACK_W  = 50;
  localparam int GAP_W  = 20;
  localparam int MAXR   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, cmd_ack;
  logic [7:0] cmd_data, status, deltaX, deltaY;
  logic       cmd_req, tx, stream_on, fail;

  int vec_cnt = 0;
  int err_cnt = 0;
  int tx_cnt = 0;
  int req_rises = 0;
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  mouse_packet_sequencer #(
    .INIT_WAIT_CYC (INIT_W),
    .ACK_WAIT_CYC  (ACK_W),
    .BYTE_GAP_CYC  (GAP_W),
    .MAX_RETRY     (MAXR)
  ) dut (
    .qzt_clk   (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .cmd_data  (cmd_data),
    .cmd_req   (cmd_req),
    .cmd_ack   (cmd_ack),
    .status    (status),
    .deltaX    (deltaX),
    .deltaY    (deltaY),
    .tx        (tx),
    .stream_on (stream_on),
    .fail      (fail)
  );

  // Event counters sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (tx) tx_cnt++;
    if (cmd_req && !req_q) req_rises++;
    req_q = cmd_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = err;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
  endtask

  task automatic chk_pkt(input string tag, input logic [7:0] s, input logic [7:0] x,
                         input logic [7:0] y, input int t0);
    chk({tag, "_tx"}, {31'd0, tx}, 32'd1);
    chk({tag, "_st"}, {24'd0, status}, {24'd0, s});
    chk({tag, "_dx"}, {24'd0, deltaX}, {24'd0, x});
    chk({tag, "_dy"}, {24'd0, deltaY}, {24'd0, y});
    @(negedge clk);
    chk({tag, "_tx_low"}, {31'd0, tx}, 32'd0);
    chk({tag, "_ntx"}, tx_cnt - t0, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_st"}, {24'd0, status}, 32'h00);
    chk({tag, "_dx"}, {24'd0, deltaX}, 32'h00);
    chk({tag, "_dy"}, {24'd0, deltaY}, 32'h00);
    chk({tag, "_tx"}, {31'd0, tx}, 32'd0);
    chk({tag, "_req"}, {31'd0, cmd_req}, 32'd0);
    chk({tag, "_son"}, {31'd0, stream_on}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
    chk({tag, "_cmd"}, {24'd0, cmd_data}, 32'hF4);
  endtask

  // Wait (bounded) for cmd_req; k returns the number of cycles waited.
  task automatic wait_req(input int n, output int k);
    k = 0;
    while (!cmd_req && k < n) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", {31'd0, cmd_req}, 32'd1);
  endtask

  task automatic do_ack();
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk("req_drop", {31'd0, cmd_req}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t0, r0, k;
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; cmd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;

    // Init handshake
    send(8'hAA, 1'b0);
    send(8'h00, 1'b0);
    chk("req_not_yet", {31'd0, cmd_req}, 32'd0);
    wait_req(10, k);
    do_ack();
    send(8'hFA, 1'b0);
    chk("stream_on", {31'd0, stream_on}, 32'd1);
    chk("no_fail", {31'd0, fail}, 32'd0);

    // Plain packet
    t0 = tx_cnt;
    send3(8'h18, 8'h05, 8'hFE);
    chk_pkt("pkt", 8'h18, 8'h05, 8'hFE, t0);

    // Resync: leading byte without sync bit is dropped
    t0 = tx_cnt;
    send(8'h00, 1'b0);
    send3(8'h08, 8'h01, 8'h02);
    chk_pkt("resync", 8'h08, 8'h01, 8'h02, t0);

    // Outputs hold between packets
    t0 = tx_cnt;
    repeat (4) @(negedge clk);
    send(8'h00, 1'b0);
    chk("hold_st", {24'd0, status}, 32'h08);
    chk("hold_dy", {24'd0, deltaY}, 32'h02);
    chk("hold_ntx", tx_cnt - t0, 32'd0);

    // Byte gap timeout drops the partial packet
    t0 = tx_cnt;
    send(8'h08, 1'b0);
    send(8'h01, 1'b0);
    repeat (GAP_W + 1) @(negedge clk);
    send3(8'h09, 8'h03, 8'h04);
    chk_pkt("gap", 8'h09, 8'h03, 8'h04, t0);

    // rx_err together with rx_valid mid-packet: byte dropped, packet aborted
    t0 = tx_cnt;
    send(8'h08, 1'b0);
    send(8'h55, 1'b1);
    send3(8'h0A, 8'h0B, 8'h0C);
    chk_pkt("rxerr", 8'h0A, 8'h0B, 8'h0C, t0);

    // Overflow bits
    t0 = tx_cnt;
    send3(8'h58, 8'h80, 8'h10);
`ifdef MOUSE_OVF_CLAMP_EN
    chk_pkt("ovf", 8'h48, 8'h00, 8'h10, t0);
`else
    chk_pkt("ovf", 8'h58, 8'h80, 8'h10, t0);
`endif

    // Retry: three rejected attempts end in FAIL
    do_reset();
    chk_reset("rst1");
    r0 = req_rises;
    send(8'hAA, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < MAXR; i++) begin
      wait_req(10, k);
      do_ack();
      send(8'hFE, 1'b0);
    end
    @(negedge clk);
    chk("retry_fail", {31'd0, fail}, 32'd1);
    chk("retry_nreq", req_rises - r0, 32'd3);
    chk("retry_son", {31'd0, stream_on}, 32'd0);
    repeat (ACK_W + 10) @(negedge clk);
    chk("fail_terminal_req", req_rises - r0, 32'd3);
    chk("fail_hold", {31'd0, fail}, 32'd1);

    // Reset while waiting for the ACK
    do_reset();
    chk_reset("rst2");
    send(8'hAA, 1'b0);
    send(8'h00, 1'b0);
    wait_req(10, k);
    do_ack();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // Self-test never arrives: command goes out after INIT_WAIT_CYC
    wait_req(INIT_W + 20, k);
    chk("init_to_late_enough", {31'd0, (k >= INIT_W - 5)}, 32'd1);
    do_ack();
    // No ACK: timeout triggers another attempt
    wait_req(ACK_W + 20, k);
    chk("ack_to_late_enough", {31'd0, (k >= ACK_W - 5)}, 32'd1);
    chk("ack_to_no_fail", {31'd0, fail}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
